// File: rtl/stream_fifo_ctrl.sv
// Valid/ready FIFO controller driving an external one-write, comb-read RAM.
// Optional registered almost_full output: define STREAM_FIFO_AFULL_EN.
module stream_fifo_ctrl #(
  parameter int DATA_WIDTH   = 10,
  parameter int ADDR_WIDTH   = 12
`ifdef STREAM_FIFO_AFULL_EN
  ,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 4
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ram_write_req,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic [ADDR_WIDTH:0]   level
`ifdef STREAM_FIFO_AFULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] L_FULL =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic                  w_push;
  logic                  w_pop;

  assign s_ready = reset & ~flush & (r_count != L_FULL);
  assign m_valid = (r_count != '0) & ~flush;
  assign w_push  = s_valid & s_ready;
  assign w_pop   = m_valid & m_ready;

  assign ram_write_req  = w_push;
  assign ram_write_addr = r_wr_ptr;
  assign ram_write_data = s_data;
  assign ram_read_addr  = r_rd_ptr;
  assign m_data         = ram_read_data;
  assign level          = r_count;

  always_comb begin
    w_count_nxt = r_count;
    unique case (1'b1)
      flush:            w_count_nxt = '0;
      w_push & ~w_pop:  w_count_nxt = r_count + CNT_ONE;
      ~w_push & w_pop:  w_count_nxt = r_count - CNT_ONE;
      default:          w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
    end
  end

`ifdef STREAM_FIFO_AFULL_EN
  localparam logic [ADDR_WIDTH:0] AF_TH =
    (ADDR_WIDTH+1)'(AFULL_THRESH);
  logic r_afull;

  assign almost_full = r_afull;

  // Tracks the count register, so it compares against next-state count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_afull <= 1'b0;
    else if (flush) r_afull <= 1'b0;
    else            r_afull <= (w_count_nxt >= AF_TH);
  end
`endif

endmodule

// File: tb/tb_stream_fifo_ctrl.sv
// Scoreboard bench for stream_fifo_ctrl at DEPTH=4 with a local RAM model.
// Build with STREAM_FIFO_AFULL_EN to also check almost_full (thresh 3).
module tb_stream_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [9:0] s_data = '0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [9:0] m_data;
  logic       ram_write_req;
  logic [1:0] ram_write_addr;
  logic [9:0] ram_write_data;
  logic [1:0] ram_read_addr;
  logic [9:0] ram_read_data;
  logic [2:0] level;
`ifdef STREAM_FIFO_AFULL_EN
  logic       almost_full;
`endif

  logic [9:0] mem [4];

  int n_total = 0;
  int n_bad = 0;

  logic [9:0] q[$];
  int m_lvl = 0;
  int m_wp = 0;
  int m_rp = 0;
  logic m_af = 1'b0;

  always #5 clk = ~clk;

  stream_fifo_ctrl #(
    .DATA_WIDTH(10),
    .ADDR_WIDTH(2)
`ifdef STREAM_FIFO_AFULL_EN
    ,
    .AFULL_THRESH(3)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .ram_write_req(ram_write_req),
    .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data),
    .ram_read_addr(ram_read_addr),
    .ram_read_data(ram_read_data),
    .level(level)
`ifdef STREAM_FIFO_AFULL_EN
    ,
    .almost_full(almost_full)
`endif
  );

  always_ff @(posedge clk)
    if (ram_write_req) mem[ram_write_addr] <= ram_write_data;
  assign ram_read_data = mem[ram_read_addr];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (level > 3'd4) chk("lvl_max", 32'(level), 32'd4);

  task automatic cyc(input logic sv, input logic [9:0] sd,
                     input logic mr, input logic fl);
    logic e_sr, e_mv, e_push, e_pop;
    int nl;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    #1;
    e_sr   = !fl && (m_lvl != 4);
    e_mv   = !fl && (m_lvl != 0);
    e_push = sv && e_sr;
    e_pop  = mr && e_mv;
    chk("s_ready", 32'(s_ready), 32'(e_sr));
    chk("m_valid", 32'(m_valid), 32'(e_mv));
    chk("wr_req", 32'(ram_write_req), 32'(e_push));
    chk("wr_addr", 32'(ram_write_addr), 32'(m_wp));
    chk("rd_addr", 32'(ram_read_addr), 32'(m_rp));
    chk("level", 32'(level), 32'(m_lvl));
`ifdef STREAM_FIFO_AFULL_EN
    chk("afull", 32'(almost_full), 32'(m_af));
`endif
    if (e_push) q.push_back(sd);
    if (e_pop) begin
      if (q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else chk("m_data", 32'(m_data), 32'(q.pop_front()));
    end
    if (fl) begin
      m_lvl = 0; m_wp = 0; m_rp = 0; m_af = 1'b0;
      q.delete();
    end else begin
      nl = m_lvl + (e_push ? 1 : 0) - (e_pop ? 1 : 0);
      if (e_push) m_wp = (m_wp + 1) % 4;
      if (e_pop)  m_rp = (m_rp + 1) % 4;
      m_lvl = nl;
      m_af  = (nl >= 3);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outs();
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_wr_req", 32'(ram_write_req), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_wr_addr", 32'(ram_write_addr), 32'd0);
    chk("rst_rd_addr", 32'(ram_read_addr), 32'd0);
`ifdef STREAM_FIFO_AFULL_EN
    chk("rst_afull", 32'(almost_full), 32'd0);
`endif
  endtask

  initial begin
    s_valid = 1'b1;
    s_data  = 10'h3FF;
    #2;
    chk_reset_outs();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 1; i <= 4; i++) cyc(1'b1, 10'(i), 1'b0, 1'b0);
    cyc(1'b1, 10'h005, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 10'(16 + i), 1'b1, 1'b0);
      chk("lvl_le1", 32'(level <= 3'd1), 32'd1);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) cyc(1'b1, 10'(10'h100 + i), 1'b0, 1'b0);
    cyc(1'b1, 10'h1AA, 1'b1, 1'b0);
    cyc(1'b1, 10'h1BB, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 10'h3FF, 1'b1, 1'b1);
    cyc(1'b1, 10'h2AA, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    cyc(1'b1, 10'h055, 1'b0, 1'b0);
    cyc(1'b1, 10'h066, 1'b0, 1'b0);
    s_valid = 1'b1;
    m_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs();
    m_lvl = 0; m_wp = 0; m_rp = 0; m_af = 1'b0;
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, 10'h077, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_fifo_ctrl.md
# stream_fifo_ctrl

Valid/ready FIFO controller that turns the block-RAM buffer (`ram`, one write port, combinational read port) into a streaming FIFO. It sits directly in front of the RAM instance. It accepts an upstream stream, issues RAM write requests, drives the RAM read address from its read pointer, and presents the RAM read data as a downstream stream. The RAM itself is instantiated outside this block; this block owns all pointers, occupancy and flow control.

## Interface
- DATA_WIDTH, 10, stream word width; equals the RAM DATA_WIDTH
- ADDR_WIDTH, 12, RAM address width; FIFO depth DEPTH = 2^ADDR_WIDTH
- AFULL_THRESH, DEPTH-4, almost-full level; used only with STREAM_FIFO_AFULL_EN
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- flush  in  1  synchronous clear of FIFO contents
- s_valid  in  1  upstream word valid
- s_ready  out  1  FIFO can accept a word
- s_data  in  DATA_WIDTH  upstream word
- m_valid  out  1  FIFO holds a word for downstream
- m_ready  in  1  downstream accepts the word
- m_data  out  DATA_WIDTH  head word; wired from ram_rd_data
- ram_write_req  out  1  RAM write enable
- ram_write_addr  out  ADDR_WIDTH  RAM write address (= wr_ptr)
- ram_write_data  out  DATA_WIDTH  RAM write data (= s_data)
- ram_read_addr  out  ADDR_WIDTH  RAM read address (= rd_ptr)
- ram_read_data  in  DATA_WIDTH  RAM combinational read data
- level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- almost_full  out  1  present only with STREAM_FIFO_AFULL_EN

## Operation
- State: wr_ptr and rd_ptr, each ADDR_WIDTH bits and wrapping modulo DEPTH; count, ADDR_WIDTH+1 bits.
- push = s_valid & s_ready. pop = m_valid & m_ready.
- s_ready = reset & ~flush & (count != DEPTH). m_valid = (count != 0) & ~flush.
- ram_write_req = push, combinational. ram_write_addr and ram_write_data pass straight through.
- ram_read_addr = rd_ptr. m_data = ram_read_data.
- On push: wr_ptr += 1 (DEPTH-1 wraps to 0).
- On pop: rd_ptr += 1, with the same wrap.
- count update:
  - push only: +1
  - pop only: −1
  - both: unchanged
- When full, s_ready=0, so push cannot occur. A pop in that cycle frees one slot, which is usable on the next cycle. There is no same-cycle passthrough.
- When empty, m_valid=0 and no pop occurs. There is no fall-through of s_data to m_data.
- flush=1 sets wr_ptr, rd_ptr and count to 0 on the clock edge. It overrides any push or pop in that cycle, which is why s_ready and m_valid are forced low while flush is high. RAM contents are left stale.
- level = count.
- Overflow and underflow are impossible by construction. A bench assertion flags count > DEPTH.

## Timing
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0
  - s_ready=0, m_valid=0, ram_write_req=0, level=0, almost_full=0
  - ram_read_addr=0, ram_write_addr=0
  - m_data follows RAM content at address 0; it is don't-care.
- Reset deasserts: s_ready=1 in the same cycle, and the first push is accepted on the next edge.
- Write latency: a word pushed at edge N is written into the RAM at edge N. m_valid rises after edge N, provided it was the only word.
  - m_data is valid in cycle N+1, read from the RAM through its combinational port.
- Pop at edge N advances rd_ptr, so m_data shows the next word in cycle N+1.
- Throughput is one word per cycle in each direction, including simultaneous push and pop at any non-empty, non-full level.
- A mid-stream reset or flush discards all contents. No partial word survives.

## Configuration
- STREAM_FIFO_AFULL_EN defined:
  - almost_full is a registered output, set when the next-state count ≥ AFULL_THRESH.
  - It updates on the same edge as count, and flush clears it.
- Undefined: the almost_full port and its register do not exist. All other behaviour is identical.

## Test plan
- ADDR_WIDTH=2 (DEPTH=4), push 0x001..0x004 with m_ready=0 → s_ready=0 after 4th push, level=4; 5th s_valid word 0x005 not written (ram_write_req=0).
- Then m_ready=1, s_valid=0 → m_data 0x001,0x002,0x003,0x004 on consecutive cycles, m_valid=0 after, level=0, rd_ptr wrapped to 0.
- Continuous push+pop 20 words (0x010..0x023) with m_ready=1 → output order identical, level never exceeds 1, pointers wrap 5 times with no loss.
- Full FIFO, s_valid=1 and m_ready=1 same cycle → pop only, level 4→3; push accepted next cycle, level back to 4.
- level=3, assert flush with s_valid=1 and m_ready=1 → next cycle level=0, m_valid=0, no RAM write during flush cycle; then push 0x2AA → m_data=0x2AA.
- Drop reset to 0 asynchronously mid-stream (level=2) → outputs immediately at reset values; after release, FIFO empty. With STREAM_FIFO_AFULL_EN and AFULL_THRESH=3, pushing a 3rd word sets almost_full on that edge, and a pop clears it.
